// File: rtl/alu_sequencer.sv
// alu_sequencer: four-register instruction sequencer driving an external combinational ALU
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       done,
  output logic       halted,
  input  logic [1:0] dbg_sel,
  output logic [3:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB, HALT} state_t;
  state_t state, state_nxt;
  logic [3:0] r [4];
  logic [7:0] ir;
  logic [3:0] hold_res;
  logic       hold_c, hold_z;
  logic       accept;
  assign accept      = state == IDLE && instr_valid;
  assign instr_ready = state == IDLE && rst_n;
  assign done        = state == WB;
  assign halted      = state == HALT;
  assign dbg_data    = r[dbg_sel];
  always_comb begin
    state_nxt = state == IDLE ? (!instr_valid ? IDLE : instr[7:6] == 2'b00 ? EXEC : instr[7:6] == 2'b11 ? HALT : WB) :
                state == EXEC ? WB :
                state == WB   ? IDLE : HALT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      r          <= '{default: '0};
      ir         <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      hold_res   <= '0;
      hold_c     <= 1'b0;
      hold_z     <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ir <= instr;
        if (instr[7:6] == 2'b00) begin
          alu_a   <= r[instr[3:2]];
          alu_b   <= r[instr[1:0]];
          alu_sel <= instr[5:4];
        end
      end
      if (state == EXEC) begin
        hold_res <= alu_out;
        hold_c   <= alu_carry;
        hold_z   <= alu_zero;
      end
      if (state == WB && ir[7:6] == 2'b00) begin
        r[ir[3:2]] <= hold_res;
        carry_flag <= hold_c;
        zero_flag  <= hold_z;
      end
      if (state == WB && ir[7:6] == 2'b01)
        r[ir[5:4]] <= ir[3:0];
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed plus random instruction streams checked against an architectural register model
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic [1:0] dbg_sel = '0;
  logic       instr_ready, alu_carry, alu_zero, carry_flag, zero_flag, done, halted;
  logic [3:0] alu_a, alu_b, alu_out, dbg_data;
  logic [1:0] alu_sel;
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [3:0] m [4];
  logic       mc, mz;
  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .carry_flag(carry_flag), .zero_flag(zero_flag), .done(done),
    .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  always_comb begin
    {alu_carry, alu_out} = alu_sel == 2'b11 ? 5'(alu_a) + 5'(alu_b) :
                           {1'b0, alu_sel == 2'b00 ? alu_a & alu_b : alu_sel == 2'b01 ? alu_a | alu_b : alu_a ^ alu_b};
    alu_zero = alu_out == 4'h0;
  end
  always @(negedge clk) if (done) done_cnt++;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [7:0] i);
    logic [4:0] s;
    int rd, rb;
    rd = int'(i[3:2]);
    rb = int'(i[1:0]);
    if (i[7:6] == 2'b00) begin
      case (i[5:4])
        2'b00:   s = {1'b0, m[rd] & m[rb]};
        2'b01:   s = {1'b0, m[rd] | m[rb]};
        2'b10:   s = {1'b0, m[rd] ^ m[rb]};
        default: s = 5'(m[rd]) + 5'(m[rb]);
      endcase
      m[rd] = s[3:0];
      mc = s[4];
      mz = s[3:0] == 4'h0;
    end else if (i[7:6] == 2'b01) begin
      m[int'(i[5:4])] = i[3:0];
    end
  endtask
  task automatic model_reset();
    for (int j = 0; j < 4; j++) m[j] = '0;
    mc = 1'b0;
    mz = 1'b0;
  endtask
  task automatic chk_state(input string tag);
    for (int j = 0; j < 4; j++) begin
      dbg_sel = j[1:0];
      #1;
      chk({tag, "_reg"}, 8'(dbg_data), 8'(m[j]));
    end
    chk({tag, "_carry"}, 8'(carry_flag), 8'(mc));
    chk({tag, "_zero"}, 8'(zero_flag), 8'(mz));
  endtask
  task automatic issue(input logic [7:0] i);
    logic [3:0] ea, eb;
    logic [1:0] rd;
    ea = m[int'(i[3:2])];
    eb = m[int'(i[1:0])];
    rd = i[7:6] == 2'b00 ? i[3:2] : i[5:4];
    chk("idle_ready", 8'(instr_ready), 8'd1);
    instr = i;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    if (i[7:6] == 2'b11) begin
      chk("halt_halted", 8'(halted), 8'd1);
      chk("halt_ready", 8'(instr_ready), 8'd0);
      chk("halt_done", 8'(done), 8'd0);
      return;
    end
    if (i[7:6] == 2'b00) begin
      chk("exec_a", 8'(alu_a), 8'(ea));
      chk("exec_b", 8'(alu_b), 8'(eb));
      chk("exec_sel", 8'(alu_sel), 8'(i[5:4]));
      chk("exec_done", 8'(done), 8'd0);
      chk("exec_ready", 8'(instr_ready), 8'd0);
      @(posedge clk);
      @(negedge clk);
      chk("wb_a_hold", 8'(alu_a), 8'(ea));
      chk("wb_sel_hold", 8'(alu_sel), 8'(i[5:4]));
    end
    chk("wb_done", 8'(done), 8'd1);
    chk("wb_ready", 8'(instr_ready), 8'd0);
    dbg_sel = rd;
    #1;
    chk("wb_old_value", 8'(dbg_data), 8'(m[int'(rd)]));
    model(i);
    @(posedge clk);
    @(negedge clk);
    chk("idle_done", 8'(done), 8'd0);
    chk("idle_ready_after", 8'(instr_ready), 8'd1);
    if (i[7:6] == 2'b00) chk("idle_b_hold", 8'(alu_b), 8'(eb));
    chk_state("post");
  endtask
  initial begin
    int c0, k;
    logic [7:0] q [3];
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 8'(instr_ready), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_halted", 8'(halted), 8'd0);
    chk("rst_alu", {2'b0, alu_sel, alu_a | alu_b}, 8'd0);
    chk_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 8'(instr_ready), 8'd1);
    @(negedge clk);
    c0 = done_cnt;
    issue(8'h59);
    issue(8'h68);
    issue(8'h36);
    dbg_sel = 2'd1;
    #1;
    chk("add_r1", 8'(dbg_data), 8'h1);
    chk("add_carry", 8'(carry_flag), 8'd1);
    chk("add_zero", 8'(zero_flag), 8'd0);
    chk("add_done_cnt", 8'(done_cnt - c0), 8'd3);
    @(negedge clk);
    issue(8'h45);
    issue(8'h20);
    chk("xor_zero", 8'(zero_flag), 8'd1);
    chk("xor_carry", 8'(carry_flag), 8'd0);
    @(negedge clk);
    c0 = done_cnt;
    issue(8'h80);
    #1;
    chk("nop_done_cnt", 8'(done_cnt - c0), 8'd1);
    @(negedge clk);
    q = '{8'h36, 8'h35, 8'h24};
    k = 0;
    instr = q[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      chk("b2b_ready", 8'(instr_ready), 8'(c % 3 == 0));
      chk("b2b_done", 8'(done), 8'(c % 3 == 2));
      if (instr_ready) begin
        model(q[k]);
        k++;
      end
      @(posedge clk);
      @(negedge clk);
      instr_valid = k < 3;
      if (k < 3) instr = q[k];
    end
    chk("b2b_accepted", 8'(k), 8'd3);
    chk_state("b2b");
    @(negedge clk);
    issue(8'h7F);
    issue(8'hC0);
    instr = 8'h70;
    instr_valid = 1'b1;
    c0 = done_cnt;
    repeat (4) begin
      @(negedge clk);
      chk("halted_hold", 8'(halted), 8'd1);
      chk("halted_ready", 8'(instr_ready), 8'd0);
      chk("halted_done", 8'(done), 8'd0);
    end
    instr_valid = 1'b0;
    dbg_sel = 2'd3;
    #1;
    chk("halted_r3", 8'(dbg_data), 8'hF);
    chk("halted_done_cnt", 8'(done_cnt - c0), 8'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("halt_exit_ready", 8'(instr_ready), 8'd1);
    @(negedge clk);
    issue(8'h5A);
    issue(8'h63);
    instr = 8'h36;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    dbg_sel = 2'd1;
    #1;
    chk("rst_exec_r1", 8'(dbg_data), 8'hA);
    rst_n = 1'b0;
    c0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    chk("rst_exec_ready", 8'(instr_ready), 8'd0);
    chk("rst_exec_done", 8'(done), 8'd0);
    chk("rst_exec_alu_a", 8'(alu_a), 8'd0);
    model_reset();
    chk_state("rst_exec");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_exec_rel_ready", 8'(instr_ready), 8'd1);
    chk("rst_exec_done_cnt", 8'(done_cnt - c0), 8'd0);
    @(negedge clk);
    for (int n = 0; n < 60; n++) begin
      logic [7:0] ri;
      ri = {2'($urandom_range(0, 2)), 6'($urandom)};
      issue(ri);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("rand_idle_ready", 8'(instr_ready), 8'd1);
      end
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The port list SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- instr  in  8  instruction word
- instr_valid  in  1  instr is presented
- instr_ready  out  1  block can accept instr
- alu_a  out  4  ALU operand A
- alu_b  out  4  ALU operand B
- alu_sel  out  2  ALU op: 00 AND, 01 OR, 10 XOR, 11 ADD
- alu_out  in  4  ALU result, combinational from alu_a/alu_b/alu_sel
- alu_carry  in  1  ALU carry out
- alu_zero  in  1  ALU zero flag
- carry_flag  out  1  registered carry of last ALU op
- zero_flag  out  1  registered zero of last ALU op
- done  out  1  one-cycle pulse per retired instruction
- halted  out  1  HALT executed
- dbg_sel  in  2  register-file read select
- dbg_data  out  4  R[dbg_sel], combinational

Function
REQ-003 The register file SHALL be R0..R3, each 4 bits.
REQ-004 Decoding SHALL use instr[7:6]:
- 00 = ALU: sel=[5:4], rd=[3:2], rb=[1:0], R[rd] <= R[rd] op R[rb]
- 01 = LOADI: rd=[5:4], R[rd] <= [3:0]
- 10 = NOP
- 11 = HALT
REQ-005 The FSM states SHALL be IDLE, EXEC, WB and HALT.
REQ-006 instr_ready SHALL be 1 only in IDLE with rst_n high.
REQ-007 An instruction SHALL be accepted on a rising edge where instr_valid && instr_ready; the block SHALL latch instr on that edge.
REQ-008 If instr_valid is low in IDLE, the block SHALL stay in IDLE with no state change.
REQ-009 On acceptance the next state SHALL be:
- ALU -> EXEC
- LOADI or NOP -> WB
- HALT -> HALT
REQ-010 In EXEC, alu_a SHALL equal R[rd] and alu_b SHALL equal R[rb]; both SHALL be registered on the accept edge, and alu_sel SHALL equal sel.
REQ-011 On the EXEC->WB edge, the block SHALL capture alu_out, alu_carry and alu_zero into internal holding registers.
REQ-012 On the WB->IDLE edge:
- ALU: write the held result to R[rd], carry_flag <= held carry, zero_flag <= held zero
- LOADI: write the immediate to R[rd]; flags unchanged
- NOP: no writes
REQ-013 done SHALL be 1 for exactly the cycle the FSM is in WB.
REQ-014 Latency from the accept edge to the register write edge SHALL be 2 cycles for ALU and 1 cycle for LOADI/NOP.
REQ-015 Minimum issue interval SHALL be 3 cycles for ALU and 2 cycles for LOADI/NOP.
REQ-016 When rd == rb, the ALU SHALL use the pre-write value for both operands (e.g. ADD R1,R1 doubles R1).
REQ-017 ADD SHALL wrap modulo 16, with carry_flag = bit 4 of the sum; AND/OR/XOR SHALL take carry from alu_carry (0 from the ALU).
REQ-018 alu_a, alu_b and alu_sel SHALL hold their last values outside EXEC and SHALL NOT glitch to unrelated registers.
REQ-019 In HALT: halted=1, instr_ready=0, done=0, no register or flag change; only reset exits HALT.
REQ-020 dbg_data SHALL reflect a register write in the cycle after the write edge.

Reset
REQ-021 When rst_n is low at a rising edge, the block SHALL set:
- state = IDLE
- R0..R3 = 0
- carry_flag = 0, zero_flag = 0
- done = 0, halted = 0
- alu_a = 0, alu_b = 0, alu_sel = 00
- all holding registers = 0
REQ-022 Reset asserted in EXEC or WB SHALL abort the instruction with no register write, no flag update and no done pulse.
REQ-023 instr_ready SHALL be 0 while rst_n is low and SHALL be 1 in the first cycle after release.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios:
- LOADI R1,0x9; LOADI R2,0x8; ADD R1,R2 -> R1=0x1, carry_flag=1, zero_flag=0, done pulses 3 times
- LOADI R0,0x5; XOR R0,R0 -> alu_a=alu_b=0x5 in EXEC; R0=0x0, zero_flag=1, carry_flag=0
- instr_valid held high with back-to-back ALU ops -> instr_ready low in EXEC/WB, accepts spaced exactly 3 cycles, no instruction lost
- LOADI R3,0xF; HALT; then valid LOADI R3,0x0 -> halted=1, instr_ready=0, R3 stays 0xF, no done
- ADD accepted, then rst_n low during EXEC -> R[rd] unchanged-then-cleared to 0, no done, instr_ready=1 the cycle after release
- NOP -> done pulses once 1 cycle after accept; R0..R3 and flags unchanged
